// File: rtl/edge_pkg.sv
// Shared types and default image geometry for the edge-detection pipeline.
package edge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int unsigned IMG_W_DEF    = 640;
  localparam int unsigned IMG_H_DEF    = 480;
  localparam int unsigned DW_DEF       = 8;
  localparam int unsigned CW_DEF       = 10;
  localparam int unsigned RW_DEF       = 9;
  localparam int unsigned DRAIN_TO_DEF = 16;

endpackage

// File: rtl/pix_cnt2d.sv
// Column/row position counter with wrap; clr_i makes the current beat (0,0).
module pix_cnt2d #(
  parameter int unsigned W  = 640,
  parameter int unsigned H  = 480,
  parameter int unsigned CW = 10,
  parameter int unsigned RW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          adv_i,
  output logic [CW-1:0] col_o,
  output logic [RW-1:0] row_o,
  output logic          last_o
);

  localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);

  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;

  // Position of the current beat, then the position after it when it advances
  always_comb begin
    cur_col = clr_i ? '0 : col_q;
    cur_row = clr_i ? '0 : row_q;
    col_d   = cur_col;
    row_d   = cur_row;
    if (adv_i) begin
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign last_o = (cur_col == COL_LAST) && (cur_row == ROW_LAST);

endmodule

// File: rtl/gs_frame_ctrl.sv
// Frame sequencer ahead of the 3x3 Gaussian filter: generates sop/eop for the
// filter input, tracks filter output position, flags malformed frames.
module gs_frame_ctrl
  import edge_pkg::*;
#(
  parameter int unsigned IMG_W    = IMG_W_DEF,
  parameter int unsigned IMG_H    = IMG_H_DEF,
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned CW       = CW_DEF,
  parameter int unsigned RW       = RW_DEF,
  parameter int unsigned DRAIN_TO = DRAIN_TO_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [DW-1:0] in_data,
  input  logic          in_vld,
  input  logic          in_sop,
  output logic [DW-1:0] flt_din,
  output logic          flt_din_vld,
  output logic          flt_din_sop,
  output logic          flt_din_eop,
  input  logic          flt_dout_vld,
  output logic          win_ok,
  output logic          busy,
  output logic          frame_done,
  output logic          err
);

  localparam int unsigned   TW      = $clog2(DRAIN_TO + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(DRAIN_TO - 1);

  state_e        state_q, state_d;
  logic [DW-1:0] din_q, din_d;
  logic          vld_q, vld_d, sop_q, sop_d, eop_q, eop_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [TW-1:0] tmr_q, tmr_d;

  logic          start, restart, timeout;
  logic          in_clr, in_adv, in_last;
  logic          out_clr, out_adv, out_last;
  logic [CW-1:0] in_col, out_col;
  logic [RW-1:0] in_row, out_row;
  logic          in_pos_unused;

  // Counter control is kept outside the FSM block so the last flags never loop back
  assign start   = (state_q == IDLE) & en & in_vld & in_sop;
  assign restart = (state_q == RUN) & in_vld & in_sop;
  assign timeout = (state_q == DRAIN) & ~flt_dout_vld & (tmr_q == TO_LAST);
  assign in_clr  = start | restart;
  assign in_adv  = start | ((state_q == RUN) & in_vld);
  assign out_clr = in_clr | timeout;
  assign out_adv = flt_dout_vld & (state_q != IDLE) & ~out_clr;

  pix_cnt2d #(.W(IMG_W), .H(IMG_H), .CW(CW), .RW(RW)) u_in_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (in_clr),
    .adv_i  (in_adv),
    .col_o  (in_col),
    .row_o  (in_row),
    .last_o (in_last)
  );

  pix_cnt2d #(.W(IMG_W), .H(IMG_H), .CW(CW), .RW(RW)) u_out_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (out_clr),
    .adv_i  (out_adv),
    .col_o  (out_col),
    .row_o  (out_row),
    .last_o (out_last)
  );

  assign in_pos_unused = ^{in_col, in_row};

  always_comb begin
    state_d = state_q;
    din_d   = din_q;
    vld_d   = 1'b0;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    tmr_d   = '0;

    if (in_adv) begin
      din_d = in_data;
      vld_d = 1'b1;
      sop_d = in_clr;
      eop_d = in_last;
    end

    case (state_q)
      IDLE: begin
        if (in_vld & en & ~in_sop) err_d = 1'b1;
        if (start) state_d = in_last ? DRAIN : RUN;
      end
      RUN: begin
        if (restart) err_d = 1'b1;
        if (in_adv & in_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (in_vld & in_sop) err_d = 1'b1;
        // Watchdog counts consecutive cycles with no filter output
        if (flt_dout_vld) begin
          if (out_last) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      din_q   <= '0;
      vld_q   <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      vld_q   <= vld_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      tmr_q   <= tmr_d;
    end
  end

  assign flt_din     = din_q;
  assign flt_din_vld = vld_q;
  assign flt_din_sop = sop_q;
  assign flt_din_eop = eop_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign err         = err_q;
  assign win_ok      = flt_dout_vld & (out_row >= RW'(2)) & (out_col >= CW'(2));

endmodule

// File: tb/tb_gs_frame_ctrl.sv
// Bench for gs_frame_ctrl on an 8x4 image: randomized frames checked each cycle
// against a pixel-index reference model, plus per-frame aggregate checks.
module tb_gs_frame_ctrl;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int TO = 16;

  logic       clk, rst_n, en, in_vld, in_sop, flt_dout_vld;
  logic [7:0] in_data, flt_din;
  logic       flt_din_vld, flt_din_sop, flt_din_eop, win_ok, busy, frame_done, err;

  gs_frame_ctrl #(
    .IMG_W(W), .IMG_H(H), .DW(8), .CW(3), .RW(2), .DRAIN_TO(TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .in_data      (in_data),
    .in_vld       (in_vld),
    .in_sop       (in_sop),
    .flt_din      (flt_din),
    .flt_din_vld  (flt_din_vld),
    .flt_din_sop  (flt_din_sop),
    .flt_din_eop  (flt_din_eop),
    .flt_dout_vld (flt_dout_vld),
    .win_ok       (win_ok),
    .busy         (busy),
    .frame_done   (frame_done),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: phase 0 waiting, 1 receiving, 2 draining; positions as linear indices
  int         m_phase, m_pix, m_beat, m_idle;
  logic [7:0] m_din;

  // Per-frame observations
  int cyc, n_fwd, n_sop, eop_at, n_err, n_done, n_win, first_win, dv_cnt, busy_gap;
  int last_dv_cyc, err_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_pix = 0; m_beat = 0; m_idle = 0; m_din = '0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_din"},   flt_din, 0);
    chk({tag, "_vld"},   flt_din_vld, 0);
    chk({tag, "_sop"},   flt_din_sop, 0);
    chk({tag, "_eop"},   flt_din_eop, 0);
    chk({tag, "_win"},   win_ok, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  frame_done, 0);
    chk({tag, "_err"},   err, 0);
  endtask

  task automatic clear_obs();
    n_fwd = 0; n_sop = 0; eop_at = -1; n_err = 0; n_done = 0; n_win = 0;
    first_win = -1; dv_cnt = 0; busy_gap = 0; last_dv_cyc = -1; err_cyc = -1;
  endtask

  // One clock: drive, check win_ok, step model, clock, check registered outputs
  task automatic cycle(input bit v, input bit s, input bit e, input bit dv, input logic [7:0] d);
    bit fwd, e_sop, e_eop, e_err, e_done, e_win;
    in_vld = v; in_sop = s; en = e; flt_dout_vld = dv; in_data = d;
    #1;
    e_win = dv && (m_beat / W >= 2) && (m_beat % W >= 2);
    chk("win_ok", win_ok, e_win);
    if (win_ok) begin
      n_win++;
      if (first_win < 0) first_win = dv_cnt;
    end
    if (dv) begin dv_cnt++; last_dv_cyc = cyc + 1; end

    fwd = 0; e_sop = 0; e_eop = 0; e_err = 0; e_done = 0;
    case (m_phase)
      0: begin
        if (v && e && s) begin
          fwd = 1; e_sop = 1; m_pix = 0; m_beat = 0; m_phase = 1;
        end else if (v && e) e_err = 1;
      end
      1: begin
        if (v && s) begin
          e_err = 1; fwd = 1; e_sop = 1; m_pix = 0; m_beat = 0;
        end else begin
          if (dv) m_beat = (m_beat + 1) % N;
          if (v) fwd = 1;
        end
      end
      default: begin
        if (v && s) e_err = 1;
        if (dv) begin
          m_idle = 0;
          if (m_beat == N - 1) begin
            e_done = 1; m_phase = 0; m_beat = 0;
          end else m_beat++;
        end else begin
          m_idle++;
          if (m_idle == TO) begin
            e_err = 1; m_phase = 0; m_beat = 0; m_idle = 0;
          end
        end
      end
    endcase
    if (fwd) begin
      e_eop = (m_pix == N - 1);
      m_pix++;
      m_din = d;
      if (e_eop) begin m_phase = 2; m_idle = 0; end
    end

    @(posedge clk);
    #1;
    cyc++;
    chk("flt_din_vld", flt_din_vld, fwd);
    chk("flt_din_sop", flt_din_sop, e_sop);
    chk("flt_din_eop", flt_din_eop, e_eop);
    chk("flt_din", flt_din, m_din);
    chk("frame_done", frame_done, e_done);
    chk("err", err, e_err);
    chk("busy", busy, m_phase != 0);

    if (flt_din_vld) begin
      if (flt_din_sop) n_sop++;
      if (flt_din_eop) eop_at = n_fwd;
      n_fwd++;
    end
    if (err) begin n_err++; err_cyc = cyc; end
    if (frame_done) n_done++;
    if (n_fwd > 0 && n_done == 0 && n_err == 0 && !busy) busy_gap++;
  endtask

  // Drive one frame; restart_at<0 means no second sop; early lets output beats overlap input
  task automatic run_frame(input int gapmax, input int restart_at, input int beats,
                           input bit early, input bit en_v, input bit en_rand, input bit drain_sop);
    int k, b, gap, dgap, npix, dfrom;
    bit v, s, e, dv, ds_done, finished;
    npix = (restart_at > 0 ? restart_at : 0) + N;
    dfrom = early ? N / 2 : npix;
    k = 0; b = 0; gap = 0; dgap = 0; ds_done = 0; finished = 0;
    clear_obs();
    for (int c = 0; c < 3000; c++) begin
      if (k == npix && b == beats && m_phase == 0) begin
        finished = 1;
        break;
      end
      v = 0; s = 0; dv = 0; e = en_v;
      if (k < npix) begin
        if (gap > 0) gap--;
        else begin
          v = 1; s = (k == 0) || (k == restart_at); k++;
          gap = $urandom_range(0, gapmax);
        end
      end else if (drain_sop && !ds_done) begin
        v = 1; s = 1; ds_done = 1;
      end
      if (en_rand && k > 1) e = 1'($urandom_range(0, 1));
      if (k >= dfrom && b < beats && (k == npix || b + 10 < k)) begin
        if (dgap > 0) dgap--;
        else begin
          dv = 1; b++;
          dgap = $urandom_range(0, gapmax);
        end
      end
      cycle(v, s, e, dv, 8'($urandom));
    end
    chk("frame_budget", finished, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; in_vld = 1'b0; in_sop = 1'b0; in_data = '0; flt_dout_vld = 1'b0;
    cyc = 0;
    model_reset();
    clear_obs();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    // Stray pixel without sop while idle and enabled
    cycle(1, 0, 1, 0, 8'h5a);
    chk("stray_err", n_err, 1);

    // Gapless frame, outputs only after input
    run_frame(0, -1, N, 0, 1, 0, 0);
    chk("s1_sop_cnt", n_sop, 1);
    chk("s1_eop_at", eop_at, N - 1);
    chk("s1_fwd_cnt", n_fwd, N);
    chk("s1_done", n_done, 1);
    chk("s1_err", n_err, 0);
    chk("s1_win_cnt", n_win, (W - 2) * (H - 2));
    chk("s1_first_win", first_win, 2 * W + 2);

    // Random gaps, overlapping output, en toggling mid-frame
    run_frame(5, -1, N, 1, 1, 1, 0);
    chk("s2_eop_at", eop_at, N - 1);
    chk("s2_done", n_done, 1);
    chk("s2_err", n_err, 0);
    chk("s2_busy_gap", busy_gap, 0);

    // Window count with gaps, plus a stray sop during drain
    run_frame(3, -1, N, 1, 1, 0, 1);
    chk("s3_win_cnt", n_win, (W - 2) * (H - 2));
    chk("s3_first_win", first_win, 2 * W + 2);
    chk("s3_done", n_done, 1);
    chk("s3_err", n_err, 1);

    // Restart with sop at pixel 10
    run_frame(2, 10, N, 0, 1, 0, 0);
    chk("s4_err", n_err, 1);
    chk("s4_sop_cnt", n_sop, 2);
    chk("s4_eop_at", eop_at, 10 + N - 1);
    chk("s4_done", n_done, 1);

    // Output stalls after 20 beats in drain
    run_frame(0, -1, 20, 0, 1, 0, 0);
    chk("s5_err", n_err, 1);
    chk("s5_done", n_done, 0);
    chk("s5_err_delay", err_cyc - last_dv_cyc, TO);
    chk("s5_busy", busy, 0);

    // Frame offered with en low
    run_frame(1, -1, 0, 0, 0, 0, 0);
    chk("s6_fwd_cnt", n_fwd, 0);
    chk("s6_err", n_err, 0);

    // Partial frame then asynchronous reset
    clear_obs();
    cycle(1, 1, 1, 0, 8'($urandom));
    for (int i = 0; i < 19; i++) cycle(1, 0, 1, 1, 8'($urandom));
    chk("s6_busy_pre", busy, 1);
    rst_n = 1'b0;
    flt_dout_vld = 1'b1;
    #1;
    check_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(0, 0, 1, 0, 8'h00);

    // Recovery frame after reset
    run_frame(1, -1, N, 1, 1, 0, 0);
    chk("post_rst_done", n_done, 1);
    chk("post_rst_err", n_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
